// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions: stall controller state encoding and stall counter width.
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter16.sv
// Saturating up-counter used to accumulate pipeline stall cycles.
module sat_counter16
    import hazard_stall_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inc,
    output logic [STALL_CNT_W-1:0] count
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

    logic [STALL_CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (inc && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard stall/flush controller: Mealy FSM deciding holds, bubbles and flushes each cycle.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ld_use1,
    input  logic                   ld_use2,
    input  logic                   dmem_busy,
    input  logic                   br_taken,
    input  logic                   halt_ex,
    output logic                   pc_hold,
    output logic                   ifid_hold,
    output logic                   idex_hold,
    output logic                   exmem_hold,
    output logic                   idex_bubble,
    output logic                   memwb_bubble,
    output logic                   flush_ifid,
    output logic                   flush_idex,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    state_t state_reg;
    state_t state_next;

    logic pc_hold_next;
    logic ifid_hold_next;
    logic idex_hold_next;
    logic exmem_hold_next;
    logic idex_bubble_next;
    logic memwb_bubble_next;
    logic flush_ifid_next;
    logic flush_idex_next;
    logic halted_next;
    logic ld_use;

    assign ld_use = ld_use1 | ld_use2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        pc_hold_next      = 1'b0;
        ifid_hold_next    = 1'b0;
        idex_hold_next    = 1'b0;
        exmem_hold_next   = 1'b0;
        idex_bubble_next  = 1'b0;
        memwb_bubble_next = 1'b0;
        flush_ifid_next   = 1'b0;
        flush_idex_next   = 1'b0;
        halted_next       = 1'b0;

        case (state_reg)
            RUN: begin
                if (dmem_busy) begin
                    pc_hold_next      = 1'b1;
                    ifid_hold_next    = 1'b1;
                    idex_hold_next    = 1'b1;
                    exmem_hold_next   = 1'b1;
                    memwb_bubble_next = 1'b1;
                    state_next        = MEM_WAIT;
                end else if (br_taken) begin
                    // A taken branch squashes the load-use consumer too, so no bubble.
                    flush_ifid_next = 1'b1;
                    flush_idex_next = 1'b1;
                    state_next      = FLUSH;
                end else if (ld_use) begin
                    pc_hold_next     = 1'b1;
                    ifid_hold_next   = 1'b1;
                    idex_hold_next   = 1'b1;
                    idex_bubble_next = 1'b1;
                end else if (halt_ex) begin
                    state_next = HALT;
                end
            end
            MEM_WAIT: begin
                if (dmem_busy) begin
                    pc_hold_next      = 1'b1;
                    ifid_hold_next    = 1'b1;
                    idex_hold_next    = 1'b1;
                    exmem_hold_next   = 1'b1;
                    memwb_bubble_next = 1'b1;
                end else begin
                    state_next = RUN;
                end
            end
            FLUSH: begin
                // Hazards reported now come from squashed instructions; only memory stalls matter.
                if (dmem_busy) begin
                    pc_hold_next      = 1'b1;
                    ifid_hold_next    = 1'b1;
                    idex_hold_next    = 1'b1;
                    exmem_hold_next   = 1'b1;
                    memwb_bubble_next = 1'b1;
                    state_next        = MEM_WAIT;
                end else begin
                    state_next = RUN;
                end
            end
            HALT: begin
                pc_hold_next     = 1'b1;
                ifid_hold_next   = 1'b1;
                idex_bubble_next = 1'b1;
                halted_next      = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Outputs are Mealy, so they must be masked directly while reset is asserted.
    assign pc_hold      = rst_n & pc_hold_next;
    assign ifid_hold    = rst_n & ifid_hold_next;
    assign idex_hold    = rst_n & idex_hold_next;
    assign exmem_hold   = rst_n & exmem_hold_next;
    assign idex_bubble  = rst_n & idex_bubble_next;
    assign memwb_bubble = rst_n & memwb_bubble_next;
    assign flush_ifid   = rst_n & flush_ifid_next;
    assign flush_idex   = rst_n & flush_idex_next;
    assign halted       = rst_n & halted_next;

    sat_counter16 u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_hold),
        .count (stall_cnt)
    );

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ld_use1, input, 1, EX-stage operand 1 depends on a MEM-stage load (from hazard resolve).
REQ-004 SHALL have port ld_use2, input, 1, EX-stage operand 2 depends on a MEM-stage load.
REQ-005 SHALL have port dmem_busy, input, 1, data memory not ready; MEM stage must hold.
REQ-006 SHALL have port br_taken, input, 1, EX stage resolved a taken branch or jump.
REQ-007 SHALL have port halt_ex, input, 1, HALT instruction reached EX.
REQ-008 SHALL have outputs pc_hold, ifid_hold, idex_hold, exmem_hold, each 1, hold the named register.
REQ-009 SHALL have outputs idex_bubble, memwb_bubble, each 1, load a NOP into the named register.
REQ-010 SHALL have outputs flush_ifid, flush_idex, each 1, squash wrong-path instructions.
REQ-011 SHALL have output halted, 1, core stopped; output stall_cnt, 16, stall cycles.

Function
REQ-012 SHALL implement states RUN, MEM_WAIT, FLUSH, HALT; encoding per shared package.
REQ-013 SHALL produce all hold/bubble/flush outputs combinationally from state and inputs in the same cycle (Mealy).
REQ-014 SHALL use fixed priority per cycle: dmem_busy > br_taken > ld_use1|ld_use2 > halt_ex.
REQ-015 SHALL, in RUN with dmem_busy=1: assert pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_bubble; go to MEM_WAIT.
REQ-016 SHALL, in MEM_WAIT: keep REQ-015 outputs while dmem_busy=1; on dmem_busy=0 drop all, return to RUN same edge.
REQ-017 SHALL, in RUN with br_taken=1 (dmem_busy=0): assert flush_ifid, flush_idex for that cycle; go to FLUSH.
REQ-018 SHALL, in FLUSH: ignore ld_use1/ld_use2 (squashed producers) for one cycle; return to RUN; dmem_busy still takes priority.
REQ-019 SHALL, in RUN with load-use and no higher event: assert pc_hold, ifid_hold, idex_hold, idex_bubble for exactly one cycle; stay RUN.
REQ-020 SHALL, on halt_ex with no higher event: go to HALT; HALT asserts pc_hold, ifid_hold, idex_bubble, halted every cycle until reset.
REQ-021 SHALL increment stall_cnt on each cycle pc_hold=1; saturates at 16'hFFFF, no wrap.
REQ-022 SHALL treat simultaneous br_taken and load-use as flush only; no bubble that cycle.

Reset
REQ-023 SHALL, while rst_n=0, force state RUN, stall_cnt 0, halted 0, all hold/bubble/flush 0, regardless of clk.
REQ-024 SHALL, on reset mid-MEM_WAIT or mid-HALT, resume RUN at first edge after rst_n rises.

Structure
REQ-025 SHALL take state encoding and stall_cnt width constant from shared pipeline package.
REQ-026 SHALL instantiate one sub-module, sat_counter16, for stall_cnt; FSM stays in the top module.

Verification
REQ-027 Load-use: ld_use1=1 one cycle in RUN -> pc_hold/idex_bubble 1 for 1 cycle, stall_cnt 0->1.
REQ-028 Memory wait: dmem_busy=1 for 3 cycles -> exmem_hold, memwb_bubble 1 for 3 cycles, RUN after, stall_cnt=3.
REQ-029 Branch+load-use: br_taken=1, ld_use2=1 together, then ld_use2=1 next cycle -> flush 1 cycle, no idex_bubble either cycle.
REQ-030 Halt: halt_ex=1 -> halted=1 and pc_hold=1 held 10 cycles; rst_n pulse -> RUN, halted=0, stall_cnt=0.
REQ-031 Saturation: preload stall_cnt to 16'hFFFE, two stall cycles -> stall_cnt 16'hFFFF, stays.
